// File: rtl/board_store_ctrl_pkg.sv
// board_store_ctrl_pkg: piece codes, FSM states and start-position lookup for the board store
package board_store_ctrl_pkg;
  localparam int SQUARES = 64;
  localparam int COLOR_BIT = 3;
  localparam logic [3:0] PIECE_EMPTY = 4'h0;
  localparam logic [2:0] T_PAWN = 3'd1, T_KNIGHT = 3'd2, T_BISHOP = 3'd3;
  localparam logic [2:0] T_ROOK = 3'd4, T_QUEEN = 3'd5, T_KING = 3'd6;
  typedef enum logic {IDLE, INIT} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
  // addr = {row,col}; color 1 owns rows 0-1, color 0 owns rows 6-7
  function automatic logic [3:0] init_piece(input logic [5:0] addr);
    logic [2:0] row, col, back;
    logic [3:0] p;
    row = addr[5:3];
    col = addr[2:0];
    back = (col == 3'd0 || col == 3'd7) ? T_ROOK :
           (col == 3'd1 || col == 3'd6) ? T_KNIGHT :
           (col == 3'd2 || col == 3'd5) ? T_BISHOP :
           (col == 3'd3) ? T_QUEEN : T_KING;
    p = PIECE_EMPTY;
    p[2:0] = (row == 3'd0 || row == 3'd7) ? back : (row == 3'd1 || row == 3'd6) ? T_PAWN : 3'd0;
    p[COLOR_BIT] = (row < 3'd2) && (p[2:0] != 3'd0);
    return p;
  endfunction
endpackage

// File: rtl/board_store_ctrl_rom.sv
// board_init_rom: combinational square address to start-position piece code
module board_init_rom
  import board_store_ctrl_pkg::*;
(
  input  logic [5:0] addr,
  output logic [3:0] piece
);
  assign piece = init_piece(addr);
endmodule

// File: rtl/board_store_ctrl.sv
// board_store_ctrl: 64x4 board storage with init sequencer, round-robin A/B write arbiter and read register
module board_store_ctrl
  import board_store_ctrl_pkg::*;
#(
  parameter bit AUTO_INIT = 1'b1,
  parameter int AW = 6,
  parameter int PW = 4
) (
  input  logic                  clk_25MHz,
  input  logic                  Reset,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  a_req,
  input  logic [AW-1:0]         a_addr,
  input  logic [PW-1:0]         a_piece,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [AW-1:0]         b_addr,
  input  logic [PW-1:0]         b_piece,
  output logic                  b_ack,
  input  logic [AW-1:0]         rd_addr,
  output logic [PW-1:0]         rd_piece,
  output logic [SQUARES*PW-1:0] board_flat
);
  state_t state, state_nxt;
  port_t rr_last;
  logic [AW-1:0] cnt;
  logic [PW-1:0] board [SQUARES];
  logic [PW-1:0] rom_piece;
  logic a_el, b_el, grant_a, grant_b;
  board_init_rom u_rom (.addr(cnt), .piece(rom_piece));
  assign init_busy = state == INIT;
  for (genvar i = 0; i < SQUARES; i++) begin : g_flat
    assign board_flat[i*PW +: PW] = board[i];
  end
  // a port in its ack cycle is locked out so a held request cannot commit twice
  always_comb begin
    a_el = a_req && !a_ack;
    b_el = b_req && !b_ack;
    grant_a = state == IDLE && !init_req && a_el && (!b_el || rr_last == PORT_B);
    grant_b = state == IDLE && !init_req && b_el && (!a_el || rr_last == PORT_A);
    state_nxt = state == INIT ? (cnt == AW'(SQUARES - 1) ? IDLE : INIT) : (init_req ? INIT : IDLE);
  end
  always_ff @(posedge clk_25MHz) begin
    if (Reset) begin
      state <= AUTO_INIT ? INIT : IDLE;
      cnt <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      rd_piece <= '0;
      rr_last <= PORT_B;
    end else begin
      state <= state_nxt;
      cnt <= state == INIT ? cnt + 1'b1 : '0;
      a_ack <= grant_a;
      b_ack <= grant_b;
      rd_piece <= board[rd_addr];
      rr_last <= grant_a ? PORT_A : grant_b ? PORT_B : rr_last;
    end
  end
  always_ff @(posedge clk_25MHz) begin
    if (Reset)
      for (int k = 0; k < SQUARES; k++) board[k] <= PIECE_EMPTY;
    else if (state == INIT)
      board[cnt] <= rom_piece;
    else if (grant_a)
      board[a_addr] <= a_piece;
    else if (grant_b)
      board[b_addr] <= b_piece;
  end
endmodule
